// File: rtl/mult_booth_64.sv
// mult_booth_64 -- iterative 32x32 signed radix-4 Booth multiplier.
//
// Accepts an operand pair on a start pulse, retires two multiplier bits per
// clock for 16 clocks, then presents the 64-bit signed product with a
// one-cycle ready strobe. The product holds until the next completion.
//
// Ports:
//   clock    in   1   system clock, rising edge
//   r        in   1   asynchronous active-low reset
//   start    in   1   request pulse, honoured in IDLE and DONE only
//   a        in  32   multiplicand, signed
//   b        in  32   multiplier, signed
//   busy     out  1   operation in progress
//   ready    out  1   one-cycle strobe, product/ovf valid
//   product  out 64   signed product, registered
//   ovf      out  1   product does not fit in 32-bit signed
//
// Build option: define MULT_OVF_EN to compute and register ovf; when it is
// undefined ovf is tied low and the compare logic is not built.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one Booth step per clock, 16 steps
// DONE  | product/ovf just written, ready high for this one cycle

module mult_booth_64 #(
  parameter int ITER  = 16,
  parameter int CNT_W = 5
) (
  input  logic        clock,
  input  logic        r,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        ready,
  output logic [63:0] product,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [31:0]        r_a;
  logic [33:0]        r_acc;
  logic [32:0]        r_mreg;
  logic [CNT_W-1:0]   r_cnt;
  logic [63:0]        r_product;

  logic               w_accept;
  logic               w_last;
  logic [33:0]        w_a_ext;
  logic [33:0]        w_term;
  logic [33:0]        w_sum;
  logic signed [66:0] w_shift;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == CNT_W'(ITER - 1));

  // State register
  always_ff @(posedge clock or negedge r) begin
    if (!r) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy  = (r_state == S_RUN);
  assign ready = (r_state == S_DONE);

  // Booth recoding of the low three bits of the multiplier shift register.
  // The accumulator carries two guard bits so that +/-2A of -2^31 and the
  // running partial sum never wrap.
  assign w_a_ext = {{2{r_a[31]}}, r_a};

  always_comb begin
    w_term = '0;
    case (r_mreg[2:0])
      3'b001, 3'b010: w_term = w_a_ext;
      3'b011:         w_term = w_a_ext << 1;
      3'b100:         w_term = -(w_a_ext << 1);
      3'b101, 3'b110: w_term = -w_a_ext;
      default:        w_term = '0;
    endcase
  end

  assign w_sum = r_acc + w_term;

  // {accumulator, multiplier shift register} shifted as one signed quantity.
  // After the final step the product sits in bits [64:1]: the bit below is
  // the spent Booth guard bit, the two above are accumulator sign extension.
  assign w_shift = $signed({w_sum, r_mreg}) >>> 2;

  always_ff @(posedge clock or negedge r) begin
    if (!r) begin
      r_a       <= '0;
      r_acc     <= '0;
      r_mreg    <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_a    <= a;
      r_acc  <= '0;
      r_mreg <= {b, 1'b0};
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_acc  <= w_shift[66:33];
      r_mreg <= w_shift[32:0];
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_product <= w_shift[64:1];
      end
    end
  end

  assign product = r_product;

`ifdef MULT_OVF_EN
  logic r_ovf;
  logic w_ovf;

  // Fits in 32-bit signed only when product[63:31] is all zeros or all ones.
  assign w_ovf = ~((&w_shift[64:32]) | ~(|w_shift[64:32]));

  always_ff @(posedge clock or negedge r) begin
    if (!r) begin
      r_ovf <= 1'b0;
    end else if ((r_state == S_RUN) && w_last && !w_accept) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mult_booth_64.sv
module tb_mult_booth_64;

  logic        clock;
  logic        r;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        ready;
  logic [63:0] product;
  logic        ovf;

  int checks = 0;
  int errors = 0;

`ifdef MULT_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  localparam longint LIM = 64'sd2147483648;

  mult_booth_64 dut (
    .clock   (clock),
    .r       (r),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .ready   (ready),
    .product (product),
    .ovf     (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed 64-bit multiplication and a range test.
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return OVF_ON && ((p >= LIM) || (p < -LIM));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Call at a negedge: presents operands with start high for the next edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    a     = x;
    b     = y;
    start = 1'b1;
  endtask

  // Follows an issued start. Iteration j samples the negedge after edge k+j-1.
  // inj > 0 re-pulses start (a=b=9) at iteration inj while the unit is busy.
  task automatic wait_done(input int inj, output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clock);
      if (j == 1) begin
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
      end
      if (inj > 0 && j == inj) begin
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd9;
      end
      if (inj > 0 && j == inj + 1) begin
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
      end
      if (busy) bcnt++;
      if (ready) begin
        cyc = j;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp_p, input logic exp_o);
    int cyc;
    int bc;
    issue(x, y);
    wait_done(0, cyc, bc);
    check({tag, "_lat"},  64'(cyc), 64'd17);
    check({tag, "_busy"}, 64'(bc),  64'd16);
    check({tag, "_prod"}, product,  exp_p);
    check({tag, "_ovf"},  64'(ovf), 64'(exp_o));
  endtask

  initial begin
    int cyc;
    int bc;
    int rc;
    logic [31:0] x;
    logic [31:0] y;

    r     = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_prod",  product,    64'd0);
    check("rst_ovf",   64'(ovf),   64'd0);
    repeat (2) @(negedge clock);
    r = 1'b1;
    @(negedge clock);

    run_op("p3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
    @(negedge clock);
    check("strobe_one", 64'(ready), 64'd0);
    check("hold_idle",  product,    64'h0000_0000_0000_000F);

    run_op("m7x6",   32'hFFFF_FFF9, 32'd6,          64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
    run_op("minmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, OVF_ON);
    run_op("maxx2",  32'h7FFF_FFFF, 32'd2,          64'h0000_0000_FFFF_FFFE, OVF_ON);
    run_op("zero",   32'd0,         32'h1234_5678, 64'h0,                   1'b0);
    run_op("m1xmin", 32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_8000_0000, OVF_ON);

    // Start during RUN is ignored; start in DONE is accepted back-to-back.
    @(negedge clock);
    issue(32'd2, 32'd3);
    wait_done(5, cyc, bc);
    check("ign_lat",  64'(cyc), 64'd17);
    check("ign_prod", product,  64'd6);
    issue(32'd4, 32'd4);
    wait_done(0, cyc, bc);
    check("b2b_lat",  64'(cyc), 64'd17);
    check("b2b_busy", 64'(bc),  64'd16);
    check("b2b_prod", product,  64'd16);
    repeat (3) @(negedge clock);
    check("hold_busy",  64'(busy),  64'd0);
    check("hold_ready", 64'(ready), 64'd0);
    check("hold_prod",  product,    64'd16);

    // Reset between edges in the middle of an operation.
    issue(32'd100, 32'd100);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clock);
      if (j == 1) start = 1'b0;
    end
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 r = 1'b0;
    #1;
    check("mid_rst_busy",  64'(busy),  64'd0);
    check("mid_rst_ready", 64'(ready), 64'd0);
    check("mid_rst_prod",  product,    64'd0);
    check("mid_rst_ovf",   64'(ovf),   64'd0);
    @(negedge clock);
    r  = 1'b1;
    rc = 0;
    bc = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clock);
      if (ready) rc++;
      if (busy) bc++;
    end
    check("post_rst_ready", 64'(rc), 64'd0);
    check("post_rst_busy",  64'(bc), 64'd0);
    run_op("post_rst_op", 32'd100, 32'd100, 64'd10000, 1'b0);

    // Randomized operands against the reference, with and without idle gaps.
    for (int n = 0; n < 24; n++) begin
      x = pick_operand();
      y = pick_operand();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(negedge clock);
      end
      run_op($sformatf("rnd%0d", n), x, y, ref_prod(x, y), ref_ovf(x, y));
    end

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
